// File: rtl/had_pkg.sv
// Shared HAD definitions: FSM state encodings, the NOP instruction word and the
// default sizing of the debug instruction queue.
package had_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RET = 2'd2
  } had_state_e;

  localparam logic [31:0] HAD_NOP         = 32'h0000_0013;
  localparam int unsigned HAD_DEF_DEPTH   = 4;
  localparam int unsigned HAD_DEF_TMO_CYC = 255;

endpackage : had_pkg

// File: rtl/had_inst_fifo.sv
// Circular instruction buffer for the HAD debug queue. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
// Holds the sticky overflow flag for pushes that arrive while the buffer is full.
module had_inst_fifo
  import had_pkg::*;
#(
  parameter int unsigned DEPTH = HAD_DEF_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        empty_o,
  output logic        full_o,
  output logic        ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        ovf_q;
  logic [31:0] mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full buffer is still taken when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign ovf_o   = ovf_q;

  // Pointer and overflow-flag update; flush takes priority over push and pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_i && !push_ok) ovf_q <= 1'b1;
    end
  end

  // Storage write; contents are only ever read behind a valid pointer.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; stale words are unreachable once the
    // pointers are cleared, and leaving it unreset keeps it mappable to RAM.
    if (push_ok && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule : had_inst_fifo

// File: rtl/had_inst_queue.sv
// HAD debug instruction queue. Buffers instructions written over JTAG, presents
// them one at a time to the core and waits for each to retire (with a timeout).
// In fast-download mode the sequencer drives the core interface directly and the
// issue FSM is frozen in place.
module had_inst_queue
  import had_pkg::*;
#(
  parameter int unsigned DEPTH   = HAD_DEF_DEPTH,
  parameter int unsigned TMO_CYC = HAD_DEF_TMO_CYC
) (
  input  logic        had_clk,
  input  logic        had_rst,
  input  logic        reg_had_ir_wr,
  input  logic [31:0] reg_had_ir_data,
  input  logic        reg_had_q_flush,
  input  logic        seq_had_fdl_sel,
  input  logic [31:0] seq_had_inst,
  input  logic        seq_had_inst_vld,
  input  logic        iu_had_inst_ack,
  input  logic        iu_had_xx_retire,
  output logic [31:0] had_iu_inst,
  output logic        had_iu_inst_vld,
  output logic        had_q_empty,
  output logic        had_q_full,
  output logic        had_q_ovf,
  output logic        had_q_tmo,
  output logic        had_q_busy
);

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  had_state_e  state_q;
  logic [15:0] tmo_cnt_q;
  logic        tmo_q;

  logic [31:0] head;
  logic        q_empty;
  logic        issue_ack;

  // Acks only pop the queue while the queue path owns the core interface.
  assign issue_ack = (state_q == ST_ISSUE) && !seq_had_fdl_sel && iu_had_inst_ack;

  had_inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (had_clk),
    .rst_i   (had_rst),
    .push_i  (reg_had_ir_wr),
    .pop_i   (issue_ack),
    .flush_i (reg_had_q_flush),
    .data_i  (reg_had_ir_data),
    .data_o  (head),
    .empty_o (q_empty),
    .full_o  (had_q_full),
    .ovf_o   (had_q_ovf)
  );

  // Issue FSM with retire-timeout counter; frozen while fast-download owns the core.
  always_ff @(posedge had_clk or posedge had_rst) begin
    if (had_rst) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else if (reg_had_q_flush) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else if (!seq_had_fdl_sel) begin
      case (state_q)
        ST_IDLE: begin
          if (!q_empty) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // A retire in the ack cycle belongs to an older instruction and is ignored.
          if (iu_had_inst_ack) begin
            tmo_cnt_q <= '0;
            state_q   <= ST_WAIT_RET;
          end
        end
        ST_WAIT_RET: begin
          if (iu_had_xx_retire) begin
            state_q <= q_empty ? ST_IDLE : ST_ISSUE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Give up on the in-flight word; it has already left the queue.
            tmo_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign had_iu_inst_vld = seq_had_fdl_sel ? seq_had_inst_vld : (state_q == ST_ISSUE);
  assign had_iu_inst     = seq_had_fdl_sel ? seq_had_inst :
                           (state_q == ST_ISSUE) ? head : 32'h0;

  assign had_q_empty = q_empty;
  assign had_q_tmo   = tmo_q;
  assign had_q_busy  = (state_q != ST_IDLE) || !q_empty;

endmodule : had_inst_queue
